// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the text-memory address, absorbs the
// one-cycle synchronous read latency and hands {pc, instruction, fault}
// to decode through a small shift-style FIFO with a valid/ready handshake.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] TEXT_BEGIN = 32'h0040_0000,
    parameter logic [31:0] TEXT_END   = 32'h0040_FFFF,
    parameter int unsigned FIFO_DEPTH = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instruction,
    output logic        out_fault
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;

    logic [XLEN-1:0]  fetch_pc_q,       fetch_pc_d;
    logic             inflight_q,       inflight_d;
    logic [XLEN-1:0]  inflight_pc_q,    inflight_pc_d;
    logic             inflight_fault_q, inflight_fault_d;
    logic             halted_q,         halted_d;
    logic [CNT_W-1:0] count_q,          count_d;
    logic             out_valid_q,      out_valid_d;
    fetch_entry_t     fifo_q [FIFO_DEPTH];
    fetch_entry_t     fifo_d [FIFO_DEPTH];

    logic [OCC_W-1:0] occupancy_c;
    logic             issue_c;
    logic             push_c;
    logic             pop_c;
    logic             fetch_oor_c;
    logic [CNT_W-1:0] wr_idx_c;
    fetch_entry_t     push_entry_c;

    // Next-state: redirect wins, otherwise pop/push the FIFO and issue on credit.
    always_comb begin
        fetch_pc_d       = fetch_pc_q;
        inflight_d       = inflight_q;
        inflight_pc_d    = inflight_pc_q;
        inflight_fault_d = inflight_fault_q;
        halted_d         = halted_q;
        count_d          = count_q;
        fifo_d           = fifo_q;
        wr_idx_c         = count_q;
        push_entry_c     = '0;

        // Credit counts only registered state so out_ready never reaches imem_address.
        occupancy_c = OCC_W'(count_q) + OCC_W'(inflight_q);
        fetch_oor_c = (fetch_pc_q < TEXT_BEGIN) || (fetch_pc_q > TEXT_END);
        issue_c     = !redirect_valid && !halted_q && (occupancy_c < OCC_W'(FIFO_DEPTH));
        push_c      = inflight_q && !redirect_valid;
        pop_c       = out_valid_q && out_ready && !redirect_valid;

        // Faulting fetches carry a zero word so an undriven bus never leaks out.
        push_entry_c.pc    = inflight_pc_q;
        push_entry_c.instr = inflight_fault_q ? '0 : imem_data;
        push_entry_c.fault = inflight_fault_q;

        if (redirect_valid) begin
            count_d    = '0;
            inflight_d = 1'b0;
            halted_d   = 1'b0;
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (pop_c) begin
                for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
                    fifo_d[i] = fifo_q[i + 1];
                end
                wr_idx_c = count_q - CNT_W'(1);
            end
            if (push_c) begin
                for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                    if (CNT_W'(i) == wr_idx_c) begin
                        fifo_d[i] = push_entry_c;
                    end
                end
            end
            count_d = wr_idx_c + CNT_W'(push_c);

            inflight_d = issue_c;
            if (issue_c) begin
                inflight_pc_d    = fetch_pc_q;
                inflight_fault_d = fetch_oor_c;
                halted_d         = halted_q | fetch_oor_c;
                fetch_pc_d       = fetch_pc_q + 32'd4;
            end
        end

        out_valid_d = (count_d != '0);
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q       <= RESET_PC;
            inflight_q       <= 1'b0;
            inflight_pc_q    <= '0;
            inflight_fault_q <= 1'b0;
            halted_q         <= 1'b0;
            count_q          <= '0;
            out_valid_q      <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            inflight_q       <= inflight_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_fault_q <= inflight_fault_d;
            halted_q         <= halted_d;
            count_q          <= count_d;
            out_valid_q      <= out_valid_d;
            fifo_q           <= fifo_d;
        end
    end

    assign imem_address    = fetch_pc_q;
    assign out_valid       = out_valid_q;
    assign out_pc          = fifo_q[0].pc;
    assign out_instruction = fifo_q[0].instr;
    assign out_fault       = fifo_q[0].fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios with literal
// expectations, then randomized redirect/reset/ready traffic, all checked
// every cycle against a queue-based model of the fetch stream.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] TEXT_BEGIN = 32'h0040_0000;
    localparam logic [31:0] TEXT_END   = 32'h0040_FFFF;
    localparam int          DEPTH      = 3;
    localparam logic [31:0] MEM_KEY    = 32'hA5A5_0000;

    logic        clock;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_address;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic        out_fault;

    instruction_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .TEXT_BEGIN(TEXT_BEGIN),
        .TEXT_END  (TEXT_END),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_address   (imem_address),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instruction(out_instruction),
        .out_fault      (out_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit out_of_text(input logic [31:0] a);
        return (a < TEXT_BEGIN) || (a > TEXT_END);
    endfunction

    // Synchronous text memory; out-of-range reads return an undriven bus.
    always @(posedge clock) begin
        if (out_of_text(imem_address)) imem_data <= 'x;
        else                           imem_data <= imem_address ^ MEM_KEY;
    end

    int total;
    int bad;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fetch;
    logic [31:0] m_ipc;
    bit          m_inflight;
    bit          m_ifault;
    bit          m_halted;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of the abstract fetch stream, using the inputs applied this cycle.
    task automatic model_step();
        int   occ;
        bit   issue;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_fetch    = RESET_PC;
            m_inflight = 0;
            m_halted   = 0;
        end else if (redirect_valid) begin
            mq.delete();
            m_inflight = 0;
            m_halted   = 0;
            m_fetch    = {redirect_pc[31:2], 2'b00};
        end else begin
            occ   = mq.size() + (m_inflight ? 1 : 0);
            issue = !m_halted && (occ < DEPTH);
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (m_inflight) begin
                e.pc    = m_ipc;
                e.fault = m_ifault;
                e.instr = m_ifault ? 32'h0 : (m_ipc ^ MEM_KEY);
                mq.push_back(e);
            end
            if (issue) begin
                m_inflight = 1;
                m_ipc      = m_fetch;
                m_ifault   = out_of_text(m_fetch);
                if (m_ifault) m_halted = 1;
                m_fetch    = m_fetch + 32'd4;
            end else begin
                m_inflight = 0;
            end
        end
    endtask

    task automatic compare_model();
        check32("valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
        check32("imem_address", imem_address, m_fetch);
        if (mq.size() > 0) begin
            check32("out_pc", out_pc, mq[0].pc);
            check32("out_instruction", out_instruction, mq[0].instr);
            check32("out_fault", {31'b0, out_fault}, {31'b0, mq[0].fault});
        end
    endtask

    task automatic cycle(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_model();
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(0, 5))
            0:       t = TEXT_BEGIN + (32'($urandom_range(0, 16383)) << 2);
            1:       t = TEXT_END - 32'($urandom_range(0, 15));
            2:       t = 32'($urandom);
            3:       t = TEXT_BEGIN - 32'($urandom_range(0, 8));
            4:       t = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
            default: t = TEXT_BEGIN + 32'($urandom_range(0, 255));
        endcase
        return t;
    endfunction

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        mq.delete();
        m_fetch    = RESET_PC;
        m_ipc      = 32'h0;
        m_inflight = 0;
        m_ifault   = 0;
        m_halted   = 0;
        @(negedge clock);

        cycle(1, 0, 32'h0, 1);
        cycle(1, 0, 32'h0, 1);
        check32("rst_valid", {31'b0, out_valid}, 32'h0);
        check32("rst_pc", out_pc, 32'h0);
        check32("rst_instr", out_instruction, 32'h0);
        check32("rst_fault", {31'b0, out_fault}, 32'h0);
        check32("rst_addr", imem_address, 32'h0040_0000);

        // Startup latency and gap-free streaming.
        cycle(0, 0, 32'h0, 1);
        check32("s1_lat_valid", {31'b0, out_valid}, 32'h0);
        cycle(0, 0, 32'h0, 1);
        check32("s1_first_valid", {31'b0, out_valid}, 32'h1);
        check32("s1_first_pc", out_pc, 32'h0040_0000);
        check32("s1_first_instr", out_instruction, 32'hA5E5_0000);
        cycle(0, 0, 32'h0, 1);
        check32("s1_second_pc", out_pc, 32'h0040_0004);
        check32("s1_second_instr", out_instruction, 32'hA5E5_0004);
        cycle(0, 0, 32'h0, 1);
        check32("s1_third_pc", out_pc, 32'h0040_0008);

        // Backpressure: fetch stops once the buffer plus in-flight fills.
        for (int i = 0; i < 6; i++) cycle(0, 0, 32'h0, 0);
        check32("s2_hold_valid", {31'b0, out_valid}, 32'h1);
        check32("s2_hold_pc", out_pc, 32'h0040_0008);
        check32("s2_hold_addr", imem_address, 32'h0040_0014);
        cycle(0, 0, 32'h0, 1);
        check32("s2_rel_pc0", out_pc, 32'h0040_000C);
        cycle(0, 0, 32'h0, 1);
        check32("s2_rel_pc1", out_pc, 32'h0040_0010);
        cycle(0, 0, 32'h0, 1);
        check32("s2_rel_pc2", out_pc, 32'h0040_0014);

        // Redirect with two buffered entries and one in flight.
        cycle(0, 0, 32'h0, 0);
        cycle(0, 1, 32'h0040_0100, 0);
        check32("s3_flush_valid", {31'b0, out_valid}, 32'h0);
        check32("s3_addr", imem_address, 32'h0040_0100);
        cycle(0, 0, 32'h0, 1);
        check32("s3_gap_valid", {31'b0, out_valid}, 32'h0);
        cycle(0, 0, 32'h0, 1);
        check32("s3_target_pc", out_pc, 32'h0040_0100);
        cycle(0, 0, 32'h0, 1);
        check32("s3_next_pc", out_pc, 32'h0040_0104);

        // Running off the end of text: one good entry, one fault entry, then halt.
        cycle(0, 1, 32'h0040_FFFC, 1);
        cycle(0, 0, 32'h0, 1);
        cycle(0, 0, 32'h0, 1);
        check32("s4_last_pc", out_pc, 32'h0040_FFFC);
        check32("s4_last_fault", {31'b0, out_fault}, 32'h0);
        cycle(0, 0, 32'h0, 1);
        check32("s4_fault_pc", out_pc, 32'h0041_0000);
        check32("s4_fault_flag", {31'b0, out_fault}, 32'h1);
        check32("s4_fault_instr", out_instruction, 32'h0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 32'h0, 1);
        check32("s4_halt_valid", {31'b0, out_valid}, 32'h0);
        check32("s4_halt_addr", imem_address, 32'h0041_0004);
        cycle(0, 1, 32'h0040_0000, 1);
        cycle(0, 0, 32'h0, 1);
        cycle(0, 0, 32'h0, 1);
        check32("s4_resume_pc", out_pc, 32'h0040_0000);

        // Reset with buffered and in-flight work.
        cycle(0, 0, 32'h0, 0);
        cycle(1, 0, 32'h0, 1);
        check32("s5_valid", {31'b0, out_valid}, 32'h0);
        check32("s5_addr", imem_address, 32'h0040_0000);
        check32("s5_pc", out_pc, 32'h0);
        cycle(0, 0, 32'h0, 1);
        check32("s5_lat_valid", {31'b0, out_valid}, 32'h0);
        cycle(0, 0, 32'h0, 1);
        check32("s5_first_pc", out_pc, 32'h0040_0000);

        // Misaligned target together with a handshake in the redirect cycle.
        cycle(0, 0, 32'h0, 1);
        cycle(0, 1, 32'h0040_0013, 1);
        check32("s6_valid", {31'b0, out_valid}, 32'h0);
        check32("s6_addr", imem_address, 32'h0040_0010);
        cycle(0, 0, 32'h0, 1);
        cycle(0, 0, 32'h0, 1);
        check32("s6_target_pc", out_pc, 32'h0040_0010);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            bit          r_rst;
            bit          r_rv;
            bit          r_rdy;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 299) == 0);
            r_rv  = ($urandom_range(0, 19) == 0);
            r_rdy = ($urandom_range(0, 9) < 7);
            r_pc  = r_rv ? pick_target() : 32'($urandom);
            cycle(r_rst, r_rv, r_pc, r_rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
